// File: rtl/uart_msg_arbiter_pkg.sv
// rtl/uart_msg_arbiter_pkg.sv - shared state encoding, requester indices and message codes
package uart_msg_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int REQ_ALARM     = 0;
  localparam int REQ_LEVEL_KEY = 1;
  localparam int REQ_CHANGE    = 2;
  localparam int REQ_HISTORY   = 3;
  localparam int REQ_STAGE_INC = 4;

  localparam logic [2:0] MSG_NONE      = 3'd0;
  localparam logic [2:0] MSG_ALARM     = 3'd1;
  localparam logic [2:0] MSG_LEVEL_KEY = 3'd2;
  localparam logic [2:0] MSG_CHANGE    = 3'd3;
  localparam logic [2:0] MSG_HISTORY   = 3'd4;
  localparam logic [2:0] MSG_STAGE_INC = 3'd5;

  // Message code of a requester is its index plus one; zero means idle.
  function automatic logic [2:0] msg_code(input int idx);
    return 3'(idx + 1);
  endfunction

endpackage

// File: rtl/uart_msg_arbiter_prio_enc_onehot.sv
// rtl/uart_msg_arbiter_prio_enc_onehot.sv - combinational lowest-index-wins one-hot priority encoder
module prio_enc_onehot #(
  parameter int W = 5
) (
  input  logic [W-1:0] req_vec,
  output logic [W-1:0] onehot,
  output logic         valid
);

  // x & -x isolates the lowest set bit.
  always_comb begin
    onehot = req_vec & (~req_vec + W'(1));
    valid  = |req_vec;
  end

endmodule

// File: rtl/uart_msg_arbiter.sv
// rtl/uart_msg_arbiter.sv - fixed-priority UART message arbiter with inter-message gap
// Optional SEND timeout with sticky err is enabled by defining MSG_TIMEOUT_EN.
module uart_msg_arbiter
  import uart_msg_arbiter_pkg::*;
#(
  parameter int NREQ   = 5,
  parameter int GAP    = 16,
  parameter int TO_CYC = 2_000_000,
  parameter int CNTW   = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sw,
  input  logic [NREQ-1:0] req,
  input  logic            msg_done,
  output logic [2:0]      data,
  output logic            DV,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] pending,
  output logic            err
);

  if (NREQ < 1 || NREQ > 7 || GAP < 1 || TO_CYC < 1 ||
      (64'd1 << CNTW) <= 64'(GAP) || (64'd1 << CNTW) <= 64'(TO_CYC)) begin : g_bad_cfg
    $error("uart_msg_arbiter: NREQ must be 1..7 and CNTW must hold GAP and TO_CYC");
  end

  localparam logic [CNTW-1:0] GAP_LOAD = CNTW'(GAP - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [NREQ-1:0] sel;
  logic            sel_valid;
  logic [2:0]      sel_code;

  prio_enc_onehot #(.W(NREQ)) u_prio_enc (
    .req_vec (pending),
    .onehot  (sel),
    .valid   (sel_valid)
  );

  always_comb begin
    sel_code = MSG_NONE;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) sel_code = msg_code(i);
    end
  end

`ifdef MSG_TIMEOUT_EN
  localparam logic [CNTW-1:0] TO_LAST = CNTW'(TO_CYC - 1);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pending <= '0;
      grant   <= '0;
      data    <= MSG_NONE;
      DV      <= 1'b0;
      cnt     <= '0;
`ifdef MSG_TIMEOUT_EN
      err     <= 1'b0;
`endif
    end else if (!sw) begin
      state   <= S_IDLE;
      pending <= '0;
      grant   <= '0;
      data    <= MSG_NONE;
      DV      <= 1'b0;
      cnt     <= '0;
    end else begin
      DV      <= 1'b0;
      pending <= pending | req;
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            // Clearing the granted bit overrides a same-cycle request on it.
            pending <= (pending | req) & ~sel;
            grant   <= sel;
            data    <= sel_code;
            DV      <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (msg_done) begin
            cnt   <= GAP_LOAD;
            state <= S_GAP;
`ifdef MSG_TIMEOUT_EN
          end else if (cnt == TO_LAST) begin
            err   <= 1'b1;
            cnt   <= GAP_LOAD;
            state <= S_GAP;
          end else begin
            cnt   <= cnt + CNTW'(1);
          end
`else
          end
`endif
        end
        S_GAP: begin
          if (cnt == '0) begin
            grant <= '0;
            data  <= MSG_NONE;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
